mu0_core: RTL
=============

MU0_CORE -- requirements
Module: mu0_core

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, with ports as below.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 resetN  input  1  asynchronous, active-low reset.
REQ-004 run  input  1  leaves IDLE when sampled high.
REQ-005 hold  input  1  stalls the core (memory-override window); see REQ-016.
REQ-006 memRq  output  1  memory request, one cycle per access.
REQ-007 readNotWrite  output  1  1 = read, 0 = write; valid while memRq=1.
REQ-008 addr  output  16  memory word address, always {4'h0, 12-bit address}.
REQ-009 dataIn  output  16  write data to memory (the accumulator on STO).
REQ-010 dataOut  input  16  read data from memory, valid the cycle after a read request.
REQ-011 halted  output  1  high while in HALT.
REQ-012 pc  output  12, acc  output  16  debug views of the program counter and accumulator registers.

Function
REQ-013 States SHALL be IDLE, FETCH, DECODE, EXECUTE, WRITEBACK and HALT.
REQ-014 IDLE: memRq=0; run=1 -> FETCH.
REQ-015 FETCH: memRq=1, readNotWrite=1, addr={4'h0,pc}; pc<=pc+1 modulo 2^12 (0xFFF wraps to 0x000); -> DECODE.
REQ-016 hold=1 in IDLE, FETCH or EXECUTE SHALL force memRq=0 and freeze state, pc, acc and ir.
REQ-017 hold SHALL be ignored in DECODE and WRITEBACK, so that already-requested read data is still captured.
REQ-018 DECODE: ir<=dataOut; memRq=0; -> EXECUTE.
REQ-019 EXECUTE decodes op=ir[15:12] and S=ir[11:0] as follows.
- 0 LDA, 2 ADD, 3 SUB: read with addr={4'h0,S}; -> WRITEBACK.
- 1 STO: write with readNotWrite=0, addr={4'h0,S}, dataIn=acc; -> FETCH.
- 4 JMP: pc<=S; -> FETCH.
- 5 JGE: pc<=S if acc[15]==0; -> FETCH.
- 6 JNE: pc<=S if acc!=0; -> FETCH.
- 7 STP: -> HALT.
- 8..F: no operation; -> FETCH.
REQ-020 WRITEBACK: LDA acc<=dataOut; ADD acc<=acc+dataOut; SUB acc<=acc-dataOut; all results modulo 2^16 with no flags; -> FETCH.
REQ-021 Instruction latency SHALL be 4 cycles for LDA/ADD/SUB and 3 cycles for all other opcodes, excluding hold cycles.
REQ-022 HALT: memRq=0, halted=1; exit SHALL occur only on reset; run is ignored.
REQ-023 When memRq=0, readNotWrite SHALL be 1 and dataIn SHALL hold its last value.
REQ-024 A JMP/JGE/JNE target SHALL override the FETCH increment, so the next fetch uses exactly S.

Reset
REQ-025 resetN low SHALL immediately force state=IDLE, pc=0, acc=0, ir=0, memRq=0, readNotWrite=1, addr=0, dataIn=0, halted=0.
REQ-026 Reset mid-instruction SHALL abandon the instruction with no partial acc or pc update.
REQ-027 Reset deassertion is synchronised externally; the core leaves IDLE on the first edge where run=1.

Structure
REQ-028 The opcode constants (LDA..STP) and the state encoding SHALL live in the shared package mu0_pkg.
REQ-029 A single sub-module mu0_alu SHALL compute pass/add/sub on 16-bit operands; control and registers stay in mu0_core.
REQ-030 The state machine SHALL be one registered state with a combinational next-state/output decode; outputs SHALL be glitch-free and registered or decoded from state only.

Verification
REQ-031 Program {0x0004 LDA 4, 0x2005 ADD 5, 0x1006 STO 6, 0x7000 STP}, mem[4]=0x0003, mem[5]=0x0004; assert run -> mem[6]=0x0007, acc=0x0007, halted=1 after 14 cycles, pc=0x004.
REQ-032 acc=0x0000 then SUB of 0x0001 -> acc=0xFFFF; following JGE 0x010 not taken (pc=next), JNE 0x020 taken (next fetch addr=0x0020).
REQ-033 pc=0xFFF with a no-op opcode 0x8000 at 0xFFF -> next fetch addr=0x0000.
REQ-034 Assert hold in FETCH for 5 cycles -> memRq=0 throughout, pc/acc unchanged; release -> fetch issued on the next cycle with the same addr.
REQ-035 Pulse resetN low during WRITEBACK of ADD -> acc=0, pc=0, state IDLE immediately; no memory write observed afterwards until run.
REQ-036 After STP, toggle run and hold -> halted stays 1 and memRq stays 0 until resetN.

Source files
------------

// File: rtl/mu0_pkg.sv
// Shared definitions for the MU0 accumulator core: state encoding, opcodes,
// ALU function select and small opcode-classification helpers.
package mu0_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STO = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;

  typedef enum logic [1:0] {
    ALU_PASS = 2'd0,
    ALU_ADD  = 2'd1,
    ALU_SUB  = 2'd2
  } aluFn_t;

  // Opcodes that read an operand from memory and finish in WRITEBACK.
  function automatic logic isMemRead(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic aluFn_t aluFnOf(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/mu0_alu.sv
// MU0 datapath arithmetic: pass-through, add or subtract of two 16-bit
// operands, wrapping modulo 2^16 with no flags.
module mu0_alu
  import mu0_pkg::*;
(
  input  logic [1:0]  fn,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  // Select the accumulator result for LDA/ADD/SUB.
  always_comb begin
    y = b;
    case (fn)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      default: y = b;
    endcase
  end

endmodule

// File: rtl/mu0_core.sv
// MU0 accumulator processor: 6-state control FSM with pc/acc/ir registers.
// A hold input freezes the core in IDLE/FETCH/EXECUTE so an external agent
// can own the memory bus; read data already requested is still captured.
module mu0_core
  import mu0_pkg::*;
(
  input  logic        clk,
  input  logic        resetN,
  input  logic        run,
  input  logic        hold,
  output logic        memRq,
  output logic        readNotWrite,
  output logic [15:0] addr,
  output logic [15:0] dataIn,
  input  logic [15:0] dataOut,
  output logic        halted,
  output logic [11:0] pc,
  output logic [15:0] acc
);

  state_t      state;
  state_t      nextState;
  logic [15:0] ir;
  logic [15:0] dataInQ;
  logic [15:0] aluY;
  logic [1:0]  aluFn;
  logic [3:0]  op;
  logic [11:0] operand;
  logic [11:0] addrSel;
  logic        storeNow;
  logic        takeJump;

  assign op       = ir[15:12];
  assign operand  = ir[11:0];
  assign aluFn    = aluFnOf(op);
  assign halted   = (state == HALT);
  assign addr     = {4'h0, addrSel};
  assign storeNow = memRq && !readNotWrite;
  // dataIn shows acc only during the STO write cycle and otherwise keeps
  // the last value written, so the bus does not toggle between accesses.
  assign dataIn   = storeNow ? acc : dataInQ;
  assign takeJump = (op == OP_JMP) ||
                    ((op == OP_JGE) && !acc[15]) ||
                    ((op == OP_JNE) && (acc != '0));

  mu0_alu uAlu (
    .fn (aluFn),
    .a  (acc),
    .b  (dataOut),
    .y  (aluY)
  );

  // Next-state and bus decode from the current state, ir and hold.
  always_comb begin
    nextState    = state;
    memRq        = 1'b0;
    readNotWrite = 1'b1;
    addrSel      = pc;
    case (state)
      IDLE: begin
        if (!hold && run) nextState = FETCH;
      end
      FETCH: begin
        if (!hold) begin
          memRq     = 1'b1;
          nextState = DECODE;
        end
      end
      DECODE: begin
        nextState = EXECUTE;
      end
      EXECUTE: begin
        addrSel = operand;
        if (!hold) begin
          if (isMemRead(op)) begin
            memRq     = 1'b1;
            nextState = WRITEBACK;
          end else if (op == OP_STO) begin
            memRq        = 1'b1;
            readNotWrite = 1'b0;
            nextState    = FETCH;
          end else if (op == OP_STP) begin
            nextState = HALT;
          end else begin
            nextState = FETCH;
          end
        end
      end
      WRITEBACK: begin
        addrSel   = operand;
        nextState = FETCH;
      end
      HALT: begin
        nextState = HALT;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // State and architectural registers; hold freezes pc/acc/ir updates.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= IDLE;
      pc      <= '0;
      acc     <= '0;
      ir      <= '0;
      dataInQ <= '0;
    end else begin
      state <= nextState;
      if ((state == FETCH) && !hold) pc <= pc + 12'd1;
      if (state == DECODE) ir <= dataOut;
      if ((state == EXECUTE) && !hold && takeJump) pc <= operand;
      if (storeNow) dataInQ <= acc;
      if (state == WRITEBACK) acc <= aluY;
    end
  end

endmodule
